fft_frame_seq: RTL and testbench

//  Sequences N-point frames from the input sample FIFO into the FFT core's Avalon-ST sink.
//  A rising edge of fifo_full starts a burst of NUM_FRAMES frames. Each frame is FFT_LEN

---
 rtl/fft_frame_seq.sv | 128 ++++++++++++
 tb/tb_fft_frame_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_seq.sv
// Frame sequencer: on a rising edge of fifo_full, streams NUM_FRAMES frames of FFT_LEN
// samples from a show-ahead FIFO into the FFT core's Avalon-ST sink.
module fft_frame_seq #(
  parameter int FFT_LEN    = 512,
  parameter int NUM_FRAMES = 1,
  parameter int GAP_CYC    = 0,
  parameter int MUX_DELAY  = 250,
  parameter int CNT_W      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic fifo_full,
  input  logic fifo_empty,
  input  logic sink_ready,
  output logic fifo_rd,
  output logic sink_valid,
  output logic sink_sop,
  output logic sink_eop,
  output logic filt_mux,
  output logic busy,
  output logic overrun
);

  typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_SMP   = CNT_W'(FFT_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_FRM   = CNT_W'(NUM_FRAMES - 1);
  localparam logic [CNT_W-1:0] LAST_GAP   = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] MUX_MAX    = CNT_W'(MUX_DELAY);

  state_t           state, state_nx;
  logic [CNT_W-1:0] sample_idx, sample_nx;
  logic [CNT_W-1:0] frame_idx, frame_nx;
  logic [CNT_W-1:0] gap_cnt, gap_nx;
  logic [CNT_W-1:0] mux_cnt;
  logic [1:0]       full_hist;
  logic             mux_on;
  logic             start, start_ok, xfer;

  assign start      = (full_hist == 2'b01);
  assign start_ok   = start && (state == IDLE);
  assign busy       = (state != IDLE);
  assign sink_valid = (state == STREAM) && !fifo_empty;
  assign sink_sop   = sink_valid && (sample_idx == '0);
  assign sink_eop   = sink_valid && (sample_idx == LAST_SMP);
  assign fifo_rd    = sink_valid && sink_ready;
  assign xfer       = fifo_rd;
  assign filt_mux   = mux_on && (mux_cnt == MUX_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sample_idx <= '0;
      frame_idx  <= '0;
      gap_cnt    <= '0;
      full_hist  <= 2'b11;
    end else begin
      state      <= state_nx;
      sample_idx <= sample_nx;
      frame_idx  <= frame_nx;
      gap_cnt    <= gap_nx;
      full_hist  <= {full_hist[0], fifo_full};
    end
  end

  always_comb begin
    state_nx  = state;
    sample_nx = sample_idx;
    frame_nx  = frame_idx;
    gap_nx    = gap_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx  = STREAM;
          sample_nx = '0;
          frame_nx  = '0;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (sample_idx == LAST_SMP) begin
            sample_nx = '0;
            if (frame_idx == LAST_FRM) begin
              state_nx = IDLE;
            end else begin
              frame_nx = frame_idx + ONE;
              if (GAP_CYC > 0) begin
                state_nx = GAP;
                gap_nx   = '0;
              end
            end
          end else begin
            sample_nx = sample_idx + ONE;
          end
        end
      end
      GAP: begin
        if (gap_cnt == LAST_GAP) begin
          state_nx = STREAM;
          gap_nx   = '0;
        end else begin
          gap_nx = gap_cnt + ONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // mux_on keeps filt_mux low until the first start after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mux_on  <= 1'b0;
      mux_cnt <= '0;
    end else if (start_ok) begin
      mux_on  <= 1'b1;
      mux_cnt <= '0;
    end else if (mux_on && (mux_cnt != MUX_MAX)) begin
      mux_cnt <= mux_cnt + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          overrun <= 1'b0;
    else if (start && state != IDLE)  overrun <= 1'b1;
  end

endmodule

// File: tb/tb_fft_frame_seq.sv
// Directed bench for fft_frame_seq: default instance for single-frame tests, and a
// small 3-frame/4-gap instance for burst and overrun behaviour.
module tb_fft_frame_seq;

  logic clk = 1'b0;
  logic rst;
  logic full1, empty1, ready1;
  logic rd1, valid1, sop1, eop1, mux1, busy1, ovr1;
  logic full2, empty2, ready2;
  logic rd2, valid2, sop2, eop2, mux2, busy2, ovr2;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  fft_frame_seq dut1 (
    .clk(clk), .rst(rst), .fifo_full(full1), .fifo_empty(empty1), .sink_ready(ready1),
    .fifo_rd(rd1), .sink_valid(valid1), .sink_sop(sop1), .sink_eop(eop1),
    .filt_mux(mux1), .busy(busy1), .overrun(ovr1)
  );

  fft_frame_seq #(.FFT_LEN(8), .NUM_FRAMES(3), .GAP_CYC(4), .MUX_DELAY(10)) dut2 (
    .clk(clk), .rst(rst), .fifo_full(full2), .fifo_empty(empty2), .sink_ready(ready2),
    .fifo_rd(rd2), .sink_valid(valid2), .sink_sop(sop2), .sink_eop(eop2),
    .filt_mux(mux2), .busy(busy2), .overrun(ovr2)
  );

  // Produces a 0->1 edge on fifo_full; returns at the negedge just after edge E0.
  task automatic start1();
    @(negedge clk); full1 = 1'b0;
    @(negedge clk); full1 = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    full1 = 1'b0; empty1 = 1'b0; ready1 = 1'b1;
    full2 = 1'b0; empty2 = 1'b0; ready2 = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    vecs++;
    if ({rd1, valid1, sop1, eop1, mux1, busy1, ovr1} !== 7'b0) begin
      errs++; $display("FAIL reset_dut1 got %b expected 0000000", {rd1, valid1, sop1, eop1, mux1, busy1, ovr1});
    end
    vecs++;
    if ({rd2, valid2, sop2, eop2, mux2, busy2, ovr2} !== 7'b0) begin
      errs++; $display("FAIL reset_dut2 got %b expected 0000000", {rd2, valid2, sop2, eop2, mux2, busy2, ovr2});
    end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vecs++;
    if ({busy1, valid1, busy2, valid2} !== 4'b0) begin
      errs++; $display("FAIL reset_release got %b expected 0000", {busy1, valid1, busy2, valid2});
    end
  endtask

  task automatic test_single_frame();
    logic [3:0] exp;
    start1();
    #1;
    vecs++;
    if ({busy1, valid1} !== 2'b00) begin
      errs++; $display("FAIL t1_latency got busy/valid=%b expected 00", {busy1, valid1});
    end
    for (int i = 0; i < 512; i++) begin
      @(negedge clk); ready1 = 1'b1; empty1 = 1'b0; #1;
      exp = {1'b1, 1'b1, i == 0, i == 511};
      vecs++;
      if ({valid1, rd1, sop1, eop1} !== exp) begin
        errs++; $display("FAIL t1_frame i=%0d got v/rd/sop/eop=%b expected %b", i, {valid1, rd1, sop1, eop1}, exp);
      end
      vecs++;
      if (mux1 !== (i >= 250)) begin
        errs++; $display("FAIL t1_filt_mux i=%0d got %b expected %b", i, mux1, (i >= 250));
      end
    end
    @(negedge clk); #1;
    vecs++;
    if ({valid1, busy1, mux1, ovr1} !== 4'b0010) begin
      errs++; $display("FAIL t1_end got v/busy/mux/ovr=%b expected 0010", {valid1, busy1, mux1, ovr1});
    end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int nx = 0;
    logic [3:0] exp;
    start1();
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk); ready1 = (i % 2 == 1); empty1 = 1'b0; #1;
      exp = {1'b1, ready1, idx == 0, idx == 511};
      vecs++;
      if ({valid1, rd1, sop1, eop1} !== exp) begin
        errs++; $display("FAIL t2_bp i=%0d got v/rd/sop/eop=%b expected %b", i, {valid1, rd1, sop1, eop1}, exp);
      end
      if (rd1 === 1'b1) nx++;
      if (ready1) idx++;
    end
    @(negedge clk); ready1 = 1'b1; #1;
    vecs++;
    if (nx !== 512) begin
      errs++; $display("FAIL t2_xfer_count got %0d expected 512", nx);
    end
    vecs++;
    if ({valid1, busy1} !== 2'b00) begin
      errs++; $display("FAIL t2_end got v/busy=%b expected 00", {valid1, busy1});
    end
  endtask

  task automatic test_fifo_empty();
    int idx = 0;
    int nx = 0;
    logic v;
    logic [3:0] exp;
    start1();
    for (int i = 0; i < 522; i++) begin
      @(negedge clk); ready1 = 1'b1; empty1 = (i >= 100 && i < 110); #1;
      v = !empty1;
      exp = {v, v, v && idx == 0, v && idx == 511};
      vecs++;
      if ({valid1, rd1, sop1, eop1} !== exp) begin
        errs++; $display("FAIL t3_empty i=%0d idx=%0d got v/rd/sop/eop=%b expected %b", i, idx, {valid1, rd1, sop1, eop1}, exp);
      end
      if (rd1 === 1'b1) nx++;
      if (v) idx++;
    end
    @(negedge clk); empty1 = 1'b0; #1;
    vecs++;
    if (nx !== 512) begin
      errs++; $display("FAIL t3_xfer_count got %0d expected 512", nx);
    end
    vecs++;
    if ({valid1, busy1} !== 2'b00) begin
      errs++; $display("FAIL t3_end got v/busy=%b expected 00", {valid1, busy1});
    end
  endtask

  task automatic test_burst_overrun();
    logic v;
    logic [4:0] exp;
    @(negedge clk); full2 = 1'b0;
    @(negedge clk); full2 = 1'b1;
    @(negedge clk);
    for (int p = 0; p <= 32; p++) begin
      @(negedge clk);
      if (p == 5) full2 = 1'b0;
      if (p == 6) full2 = 1'b1;
      #1;
      v = (p < 32) && ((p % 12) < 8);
      exp = {v, v && (p % 12 == 0), v && (p % 12 == 7), v, p < 32};
      vecs++;
      if ({valid2, sop2, eop2, rd2, busy2} !== exp) begin
        errs++; $display("FAIL t4_burst p=%0d got v/sop/eop/rd/busy=%b expected %b", p, {valid2, sop2, eop2, rd2, busy2}, exp);
      end
      vecs++;
      if ({ovr2, mux2} !== {p >= 8, p >= 10}) begin
        errs++; $display("FAIL t4_ovr_mux p=%0d got ovr/mux=%b expected %b", p, {ovr2, mux2}, {p >= 8, p >= 10});
      end
    end
  endtask

  task automatic test_reset_cases();
    logic [3:0] exp;
    full1 = 1'b1;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      vecs++;
      if ({busy1, valid1} !== 2'b00) begin
        errs++; $display("FAIL t5_full_at_reset i=%0d got busy/valid=%b expected 00", i, {busy1, valid1});
      end
    end
    start1();
    for (int i = 0; i < 300; i++) @(negedge clk);
    #1;
    vecs++;
    if ({valid1, busy1, mux1} !== 3'b111) begin
      errs++; $display("FAIL t5_pre_rst got v/busy/mux=%b expected 111", {valid1, busy1, mux1});
    end
    rst = 1'b1; #1;
    vecs++;
    if ({rd1, valid1, sop1, eop1, mux1, busy1, ovr1} !== 7'b0) begin
      errs++; $display("FAIL t5_mid_rst got %b expected 0000000", {rd1, valid1, sop1, eop1, mux1, busy1, ovr1});
    end
    @(negedge clk); rst = 1'b0;
    start1();
    for (int i = 0; i < 512; i++) begin
      @(negedge clk); #1;
      exp = {1'b1, 1'b1, i == 0, i == 511};
      vecs++;
      if ({valid1, busy1, sop1, eop1} !== exp) begin
        errs++; $display("FAIL t5_restart i=%0d got v/busy/sop/eop=%b expected %b", i, {valid1, busy1, sop1, eop1}, exp);
      end
    end
    @(negedge clk); #1;
    vecs++;
    if ({valid1, busy1, ovr1} !== 3'b000) begin
      errs++; $display("FAIL t5_end got v/busy/ovr=%b expected 000", {valid1, busy1, ovr1});
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_fifo_empty();
    test_burst_overrun();
    test_reset_cases();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
